alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the CPU's combinational ALU. Adds iterative unsigned MUL/DIV, carry/overflow flags and valid/ready handshakes on both sides.
- Sits in the EX stage. The issue logic presents operands, the block computes, and the result is held registered until writeback accepts it.

Parameters:
- DATA_W, 16: operand/result width, >= 8.
- SH_ZERO_AMT, 8: shift amount substituted when the encoded shift amount is 0 (SLL/SRL/SRA only).
- SH_W, $clog2(DATA_W): shift-amount bits taken from a.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  block can accept.
- a  in  DATA_W  operand A (shift amount for shifts).
- b  in  DATA_W  operand B (value shifted for shifts).
- op  in  5  opcode, from the shared package.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- y  out  DATA_W  primary result (low product / quotient).
- y_hi  out  DATA_W  high product / remainder; 0 for all other ops.
- zero  out  1  y == 0.
- carry  out  1  ADD carry-out / SUB no-borrow; 0 for all other ops.
- ovf  out  1  signed overflow for ADD/SUB; 0 for all other ops.
- dz  out  1  divide by zero (DIVU with b == 0).

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, y=y_hi=0, zero=1, carry=ovf=dz=0. Reset mid-operation aborts it and discards the result.
- Accept: an input is accepted when in_valid && in_ready. a, b and op are captured on that edge; later input changes are ignored.
- States:
  - IDLE: on accept, single-cycle ops -> DONE; MUL/DIVU -> BUSY with cnt=0.
  - BUSY: one iteration per cycle; after DATA_W iterations -> DONE.
  - DONE: out_valid=1, outputs held stable. On out_ready, a simultaneous accept re-enters BUSY/DONE; otherwise -> IDLE.
- in_ready = IDLE || (DONE && out_ready). It is 0 in BUSY.
- Latency, accept to out_valid:
  - Single-cycle ops: 1 cycle, so back-to-back throughput is 1 result per cycle.
  - MUL/DIVU: DATA_W+1 cycles.
- Single-cycle ops (all DATA_W bits):
  - ADD: a+b, with carry and ovf.
  - SUB: a-b. carry=1 when a>=b unsigned. ovf is signed overflow.
  - AND, OR, XOR: bitwise.
  - NOT: ~a.
  - RETA: a. RETB: b.
  - EQU: y=1 when a!=b, else 0. This encoding is kept for branch compatibility.
  - SLL: b << sh. SRL: b >> sh (logical). SRA: b >>> sh (arithmetic). sh = a[SH_W-1:0], or SH_ZERO_AMT when that field is 0.
  - SLLV: b << a[SH_W-1:0]. Zero is a legal amount here.
  - NOP: y, y_hi and the flags keep their previous values; out_valid still asserts after 1 cycle.
  - Undefined opcodes behave as NOP.
- MUL: unsigned shift-add. {y_hi,y} = a*b (2*DATA_W-bit product).
- DIVU: unsigned restoring division. y = a/b, y_hi = a%b.
  - b == 0: y = all-ones, y_hi = a, dz=1. It still takes the full DATA_W+1 cycles.
- Flags: zero is computed on y for every op except NOP. carry/ovf/dz are 0 unless defined above for the op.

Decomposition:
- Shared package alu_pkg:
  - ALU_OP_* 5-bit opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, RETA=6, RETB=7, EQU=8, SLL=9, SLLV=10, SRA=11, SRL=12, NOP=13, MUL=16, DIVU=17.
  - State enum IDLE/BUSY/DONE.
  - Helper predicate is_multicycle(op).
- Sub-module alu_iter_muldiv:
  - Holds the shared accumulator/shift registers and the iteration counter.
  - Ports: start, is_div, a, b, busy, done, lo, hi.
- The top level holds the FSM, the single-cycle datapath and the output registers.

Test Plan (DATA_W=16):
- ADD and SUB flags:
  - ADD 0x7FFF+0x0001 -> y=0x8000, ovf=1, carry=0, zero=0, out_valid 1 cycle after accept.
  - ADD 0xFFFF+1 -> y=0, carry=1, zero=1.
- Shifts:
  - SLL a=0, b=0x0001 -> y=0x0100 (SH_ZERO_AMT substituted).
  - SRA a=4, b=0x8000 -> y=0xF800.
  - SLLV a=0, b=0x1234 -> y=0x1234.
- MUL 0xFFFF*0xFFFF -> y=0x0001, y_hi=0xFFFE.
  - out_valid exactly 17 cycles after accept.
  - in_ready=0 throughout BUSY.
- DIVU:
  - 100/7 -> y=14, y_hi=2, dz=0.
  - 5/0 -> y=0xFFFF, y_hi=5, dz=1, after 17 cycles.
- Backpressure and streaming:
  - out_ready held 0 for 5 cycles after DONE -> y and flags stable, in_ready=0.
  - Then 3 back-to-back ADDs with out_ready=1 -> one result per cycle, in order.
- Reset mid-DIVU:
  - rst pulsed at cycle 8 of BUSY -> next cycle state IDLE, out_valid=0, y=0, in_ready=1, no stale result emitted.
  - NOP after ADD 2+3 -> y stays 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode helpers for the multi-cycle ALU.
package alu_pkg;

    localparam logic [4:0] ALU_OP_ADD  = 5'd0;
    localparam logic [4:0] ALU_OP_SUB  = 5'd1;
    localparam logic [4:0] ALU_OP_AND  = 5'd2;
    localparam logic [4:0] ALU_OP_OR   = 5'd3;
    localparam logic [4:0] ALU_OP_XOR  = 5'd4;
    localparam logic [4:0] ALU_OP_NOT  = 5'd5;
    localparam logic [4:0] ALU_OP_RETA = 5'd6;
    localparam logic [4:0] ALU_OP_RETB = 5'd7;
    localparam logic [4:0] ALU_OP_EQU  = 5'd8;
    localparam logic [4:0] ALU_OP_SLL  = 5'd9;
    localparam logic [4:0] ALU_OP_SLLV = 5'd10;
    localparam logic [4:0] ALU_OP_SRA  = 5'd11;
    localparam logic [4:0] ALU_OP_SRL  = 5'd12;
    localparam logic [4:0] ALU_OP_NOP  = 5'd13;
    localparam logic [4:0] ALU_OP_MUL  = 5'd16;
    localparam logic [4:0] ALU_OP_DIVU = 5'd17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    function automatic logic is_multicycle(input logic [4:0] op);
        return (op == ALU_OP_MUL) || (op == ALU_OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one hi/lo pair.
// The first iteration runs on the start edge, so DATA_W iterations finish one cycle early.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              busy_q, div_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] b_q, lo_q, hi_q;
    logic [DATA_W-1:0] src_hi_s, src_lo_s, src_b_s, step_hi_s, step_lo_s;
    logic              src_div_s;
    logic [DATA_W:0]   mul_sum_s, div_sh_s, div_diff_s;

    // One multiply or divide iteration, fed from the operands on start, else from state.
    always_comb begin
        src_hi_s   = start ? {DATA_W{1'b0}} : hi_q;
        src_lo_s   = start ? a : lo_q;
        src_b_s    = start ? b : b_q;
        src_div_s  = start ? is_div : div_q;
        mul_sum_s  = {1'b0, src_hi_s} + (src_lo_s[0] ? {1'b0, src_b_s} : {(DATA_W+1){1'b0}});
        div_sh_s   = {src_hi_s, src_lo_s[DATA_W-1]};
        div_diff_s = div_sh_s - {1'b0, src_b_s};
        if (src_div_s) begin
            if (div_sh_s >= {1'b0, src_b_s}) begin
                step_hi_s = div_diff_s[DATA_W-1:0];
                step_lo_s = {src_lo_s[DATA_W-2:0], 1'b1};
            end else begin
                step_hi_s = div_sh_s[DATA_W-1:0];
                step_lo_s = {src_lo_s[DATA_W-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[DATA_W:1];
            step_lo_s = {mul_sum_s[0], src_lo_s[DATA_W-1:1]};
        end
    end

    assign done = busy_q && (cnt_q == CNT_W'(DATA_W));

    // Iteration state; cnt_q counts completed iterations.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
            b_q    <= {DATA_W{1'b0}};
            lo_q   <= {DATA_W{1'b0}};
            hi_q   <= {DATA_W{1'b0}};
        end else if (start) begin
            busy_q <= 1'b1;
            div_q  <= is_div;
            cnt_q  <= CNT_W'(1);
            b_q    <= b;
            lo_q   <= step_lo_s;
            hi_q   <= step_hi_s;
        end else if (done) begin
            busy_q <= 1'b0;
        end else if (busy_q) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            lo_q   <= step_lo_s;
            hi_q   <= step_hi_s;
        end else begin
            busy_q <= busy_q;
        end
    end

    assign busy = busy_q;
    assign lo   = lo_q;
    assign hi   = hi_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: handshake FSM, single-cycle datapath and registered results.
module alu_mc
    import alu_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int SH_ZERO_AMT = 8,
    parameter int SH_W        = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] y_hi,
    output logic              zero,
    output logic              carry,
    output logic              ovf,
    output logic              dz
);

    alu_state_e        state_q, state_d;
    logic              accept_s, start_s, md_done_s, md_busy_s, hold_s;
    logic              div_q, bz_q;
    logic [DATA_W-1:0] md_lo_s, md_hi_s, res_y_s;
    logic              res_carry_s, res_ovf_s;
    logic [DATA_W:0]   sum_s, diff_s;
    logic [SH_W-1:0]   sh_s;
    logic [DATA_W-1:0] y_q, y_d, y_hi_q, y_hi_d;
    logic              zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, dz_q, dz_d;

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept_s = in_valid && in_ready;
    assign start_s  = accept_s && is_multicycle(op);

    alu_iter_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (start_s),
        .is_div (op == ALU_OP_DIVU),
        .a      (a),
        .b      (b),
        .busy   (md_busy_s),
        .done   (md_done_s),
        .lo     (md_lo_s),
        .hi     (md_hi_s)
    );

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: DONE drains on out_ready, possibly chaining straight into the next op.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_d = is_multicycle(op) ? BUSY : DONE;
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            BUSY: begin
                if (md_done_s) begin
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single-cycle datapath on the live operands; hold_s marks NOP and unused opcodes.
    always_comb begin
        sum_s       = {1'b0, a} + {1'b0, b};
        diff_s      = {1'b0, a} - {1'b0, b};
        sh_s        = (a[SH_W-1:0] == {SH_W{1'b0}}) ? SH_W'(SH_ZERO_AMT) : a[SH_W-1:0];
        res_y_s     = {DATA_W{1'b0}};
        res_carry_s = 1'b0;
        res_ovf_s   = 1'b0;
        hold_s      = 1'b0;
        case (op)
            ALU_OP_ADD: begin
                res_y_s     = sum_s[DATA_W-1:0];
                res_carry_s = sum_s[DATA_W];
                res_ovf_s   = (a[DATA_W-1] == b[DATA_W-1]) && (sum_s[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_OP_SUB: begin
                res_y_s     = diff_s[DATA_W-1:0];
                res_carry_s = ~diff_s[DATA_W];
                res_ovf_s   = (a[DATA_W-1] != b[DATA_W-1]) && (diff_s[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_OP_AND:  res_y_s = a & b;
            ALU_OP_OR:   res_y_s = a | b;
            ALU_OP_XOR:  res_y_s = a ^ b;
            ALU_OP_NOT:  res_y_s = ~a;
            ALU_OP_RETA: res_y_s = a;
            ALU_OP_RETB: res_y_s = b;
            ALU_OP_EQU:  res_y_s = {{(DATA_W-1){1'b0}}, (a != b)};
            ALU_OP_SLL:  res_y_s = b << sh_s;
            ALU_OP_SLLV: res_y_s = b << a[SH_W-1:0];
            ALU_OP_SRA:  res_y_s = DATA_W'($signed(b) >>> sh_s);
            ALU_OP_SRL:  res_y_s = b >> sh_s;
            default:     hold_s  = 1'b1;
        endcase
    end

    // Result next-state: iterative unit on completion, single-cycle ops on accept, else hold.
    always_comb begin
        y_d     = y_q;
        y_hi_d  = y_hi_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        if (md_done_s) begin
            y_d     = md_lo_s;
            y_hi_d  = md_hi_s;
            zero_d  = (md_lo_s == {DATA_W{1'b0}});
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            dz_d    = div_q && bz_q;
        end else if (accept_s && !is_multicycle(op) && !hold_s) begin
            y_d     = res_y_s;
            y_hi_d  = {DATA_W{1'b0}};
            zero_d  = (res_y_s == {DATA_W{1'b0}});
            carry_d = res_carry_s;
            ovf_d   = res_ovf_s;
            dz_d    = 1'b0;
        end else begin
            y_d     = y_q;
        end
    end

    // Result registers plus the divide-by-zero context captured at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= {DATA_W{1'b0}};
            y_hi_q  <= {DATA_W{1'b0}};
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            div_q   <= 1'b0;
            bz_q    <= 1'b0;
        end else begin
            y_q     <= y_d;
            y_hi_q  <= y_hi_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            if (start_s) begin
                div_q <= (op == ALU_OP_DIVU);
                bz_q  <= (b == {DATA_W{1'b0}});
            end else begin
                div_q <= div_q;
            end
        end
    end

    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign y_hi      = y_hi_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at DATA_W=16.
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic        in_ready, out_valid, zero, carry, ovf, dz;
    logic [15:0] a, b, y, y_hi;
    logic [4:0]  op;
    int          n_checks = 0;
    int          n_errors = 0;

    alu_mc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_hi(y_hi), .zero(zero), .carry(carry), .ovf(ovf), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op, wait for its result, check it, then consume it.
    task automatic run_op(input string tag, input logic [4:0] o, input logic [15:0] av, bv,
                          input logic [15:0] ey, ehi, input logic [3:0] ef, input int elat);
        int   lat;
        logic rdy_bad;
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1);
        op = o; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = 16'hA5A5; b = 16'h5A5A; op = ALU_OP_SUB;
        lat = 0;
        rdy_bad = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) rdy_bad = 1'b1;
        end while (!out_valid && lat < 40);
        check({tag, "_latency"}, lat, elat);
        check({tag, "_busy_rdy"}, rdy_bad, 0);
        check({tag, "_y"}, y, ey);
        check({tag, "_y_hi"}, y_hi, ehi);
        check({tag, "_flags"}, {zero, carry, ovf, dz}, ef);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic stab_bad, stale;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = ALU_OP_ADD;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", {y, y_hi}, 0);
        check("rst_flags", {zero, carry, ovf, dz}, 4'b1000);
        rst = 1'b0;

        // flags order: {zero, carry, ovf, dz}
        run_op("add_ovf",   ALU_OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0010, 1);
        run_op("add_carry", ALU_OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1100, 1);
        run_op("sub_borrow",ALU_OP_SUB,  16'h0005, 16'h0007, 16'hFFFE, 16'h0000, 4'b0000, 1);
        run_op("sub_ovf",   ALU_OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0110, 1);
        run_op("sll_zero",  ALU_OP_SLL,  16'h0000, 16'h0001, 16'h0100, 16'h0000, 4'b0000, 1);
        run_op("sra",       ALU_OP_SRA,  16'h0004, 16'h8000, 16'hF800, 16'h0000, 4'b0000, 1);
        run_op("srl_zero",  ALU_OP_SRL,  16'h0000, 16'h8000, 16'h0080, 16'h0000, 4'b0000, 1);
        run_op("sllv_zero", ALU_OP_SLLV, 16'h0000, 16'h1234, 16'h1234, 16'h0000, 4'b0000, 1);
        run_op("equ_same",  ALU_OP_EQU,  16'h0003, 16'h0003, 16'h0000, 16'h0000, 4'b1000, 1);
        run_op("xor",       ALU_OP_XOR,  16'hF0F0, 16'hFF00, 16'h0FF0, 16'h0000, 4'b0000, 1);
        run_op("mul_max",   ALU_OP_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0000, 17);
        run_op("divu",      ALU_OP_DIVU, 16'd100,  16'd7,    16'd14,   16'd2,    4'b0000, 17);
        run_op("divu_dz",   ALU_OP_DIVU, 16'd5,    16'd0,    16'hFFFF, 16'd5,    4'b0001, 17);
        run_op("nop_hold",  ALU_OP_NOP,  16'h0009, 16'h0009, 16'hFFFF, 16'd5,    4'b0001, 1);

        // Backpressure: result held while out_ready stays low.
        @(negedge clk);
        op = ALU_OP_ADD; a = 16'd2; b = 16'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        stab_bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (y !== 16'd5 || y_hi !== 16'd0 || !out_valid || in_ready || zero || carry) stab_bad = 1'b1;
        end
        check("bp_stable", stab_bad, 0);
        check("bp_y", y, 16'd5);

        // Streaming: three ADDs back to back, one result per cycle.
        for (int i = 1; i <= 3; i++) begin
            out_ready = 1'b1; in_valid = 1'b1; op = ALU_OP_ADD; a = 16'(i); b = 16'(i);
            #1;
            check("stream_in_ready", in_ready, 1);
            @(posedge clk);
            @(negedge clk);
            check("stream_valid", out_valid, 1);
            check("stream_y", y, 16'(2 * i));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset during a divide aborts it.
        @(negedge clk);
        op = ALU_OP_DIVU; a = 16'd1000; b = 16'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_busy", {out_valid, in_ready}, 2'b00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_y", {y, y_hi}, 0);
        check("abort_zero", zero, 1);
        stale = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("abort_no_stale", stale, 0);

        run_op("add_2_3",   ALU_OP_ADD,  16'd2, 16'd3, 16'd5, 16'd0, 4'b0000, 1);
        run_op("nop_keep",  ALU_OP_NOP,  16'd0, 16'd0, 16'd5, 16'd0, 4'b0000, 1);
        run_op("undef_op",  5'd14,       16'd0, 16'd0, 16'd5, 16'd0, 4'b0000, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
